bcd_expand: RTL and testbench
=============================

Name: bcd_expand

Overview:
- Inverse of the frequency counter's BCD normalisation stage.
- Takes a 4-digit normalised BCD mantissa plus its decimal-shift count and rebuilds the 7-digit aligned BCD value, zero-filling the digits dropped by normalisation.
- Then converts that 7-digit value to unsigned binary for downstream arithmetic (period/frequency reciprocal, UART report).
- Multi-cycle FSMD with start/ready/done_tick handshake, matching the other counter-path stages.

Parameters:
- BIN_W, 24, binary result width. Must be ≥24 so that 9,999,999 fits.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only while ready=1.
- bcd_in3, bcd_in2, bcd_in1, bcd_in0  in  4 each  normalised mantissa, bcd_in3 = most significant.
- decimal_counter  in  2  number of leading-zero digits removed by normalisation (0..3).
- bcd6 .. bcd0  out  4 each  reconstructed 7-digit BCD, bcd6 = most significant.
- bin_out  out  BIN_W  binary value of bcd6..bcd0.
- ready  out  1  high in idle only.
- done_tick  out  1  one-cycle pulse when results are valid.

Behaviour:
- Reset (async, active-low): state=idle; digit register, count register, binary accumulator and conversion index all 0. All outputs 0 except ready=1.
- Reset mid-operation aborts immediately. No done_tick is produced.
- States: idle, shift, conv, done.
- idle:
  - ready=1.
  - On start: load digit reg = {bcd_in3, bcd_in2, bcd_in1, bcd_in0, 12'h000}, count reg = decimal_counter, accumulator = 0, conversion index = 0. Go to shift.
- shift:
  - If count ≠ 0: digit reg shifts right 4 bits (zero into the top nibble) and count decrements.
  - Else go to conv.
  - Occupies count+1 cycles.
- conv:
  - Each cycle: accumulator = accumulator×10 + current top digit, with ×10 implemented as (acc<<3)+(acc<<1).
  - Digit order is MSD first: bcd6 through bcd0, selected by the 3-bit index, without destroying the digit reg.
  - After the 7th digit, go to done. Occupies exactly 7 cycles.
- done: done_tick=1 for one cycle, then idle.
- Latency: if start is sampled at edge E0, done_tick is high during cycle decimal_counter+9 after E0. That is 9..12 cycles.
- Output validity:
  - bcd6..bcd0 are driven directly from the digit reg.
  - bin_out is driven from the accumulator.
  - Both are valid from done onward and held until the next accepted start. Intermediate values are visible while busy; consumers qualify on done_tick.
- start while busy (ready=0) is ignored. No queueing.
- start held high continuously: a new operation begins on the cycle after done, i.e. the first idle cycle.
- Non-BCD input nibbles (>9) are not checked. They are processed by the same arithmetic, with the result truncated to BIN_W. Output is deterministic but meaningless.
- Arithmetic: accumulator is BIN_W bits and never overflows for valid BCD input. Maximum is 9,999,000, since the low three digits are always 0 when count=0.

Decomposition:
- Shared counter package holds:
  - state encodings (idle, shift, conv, done; 2 bits);
  - the constant DIGITS=7;
  - the constant BCD_W=4;
  - default BIN_W=24.
- No sub-module. The ×10-add is a single combinational expression inside the block. A separate helper module is not justified.

Test Plan:
- Mantissa 1,2,3,4, decimal_counter=3 → bcd6..0 = 0,0,0,1,2,3,4; bin_out=1234; done_tick exactly 12 cycles after the start edge.
- Mantissa 9,8,7,6, decimal_counter=0 → bcd6..0 = 9,8,7,6,0,0,0; bin_out=9,876,000 (0x96B220); done_tick at cycle 9.
- Mantissa 5,0,0,1, decimal_counter=1 → 0,5,0,0,1,0,0; bin_out=500,100; done_tick at cycle 10. Then start pulsed during busy → ignored, exactly one done_tick.
- Start held high across two operations → second operation accepted on the first idle cycle. Back-to-back done_ticks separated by latency+1 cycles; ready low except in idle.
- reset asserted low in conv after 3 digits → ready=1, bin_out=0, bcd outputs 0 asynchronously. No done_tick. The next start with mantissa 0,0,0,0, decimal_counter=0 gives bin_out=0 at cycle 9.

Source files
------------

// File: rtl/bcd_expand_pkg.sv
// Shared definitions for the frequency-counter BCD path.
package bcd_expand_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CONV  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam int DIGITS    = 7;
  localparam int BCD_W     = 4;
  localparam int BIN_W_DEF = 24;

endpackage

// File: rtl/bcd_expand.sv
// De-normalises a 4-digit BCD mantissa back to 7 aligned digits using its
// decimal-shift count, then converts the 7-digit value to binary, MSD first.
module bcd_expand
  import bcd_expand_pkg::*;
#(
  parameter int BIN_W = BIN_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       bcd_in3,
  input  logic [3:0]       bcd_in2,
  input  logic [3:0]       bcd_in1,
  input  logic [3:0]       bcd_in0,
  input  logic [1:0]       decimal_counter,
  output logic [3:0]       bcd6,
  output logic [3:0]       bcd5,
  output logic [3:0]       bcd4,
  output logic [3:0]       bcd3,
  output logic [3:0]       bcd2,
  output logic [3:0]       bcd1,
  output logic [3:0]       bcd0,
  output logic [BIN_W-1:0] bin_out,
  output logic             ready,
  output logic             done_tick
);

  localparam int DIG_W = DIGITS * BCD_W;

  state_t             state_q, state_d;
  logic [DIG_W-1:0]   dig_q, dig_d;
  logic [1:0]         cnt_q, cnt_d;
  logic [BIN_W-1:0]   acc_q, acc_d;
  logic [2:0]         idx_q, idx_d;
  logic [BCD_W-1:0]   cur_digit;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      dig_q   <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      dig_q   <= dig_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
    end
  end

  // Selects the digit addressed by the conversion index (0 = bcd6), leaving
  // the digit register intact so it can still drive the BCD outputs.
  always_comb begin
    cur_digit = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (idx_q == 3'(i))
        cur_digit = dig_q[(DIGITS-1-i)*BCD_W +: BCD_W];
    end
  end

  // Next-state and datapath updates for idle/shift/conv/done.
  always_comb begin
    state_d   = state_q;
    dig_d     = dig_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    idx_d     = idx_q;
    ready     = 1'b0;
    done_tick = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ready = 1'b1;
        if (start) begin
          dig_d   = {bcd_in3, bcd_in2, bcd_in1, bcd_in0, {(3*BCD_W){1'b0}}};
          cnt_d   = decimal_counter;
          acc_d   = '0;
          idx_d   = '0;
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        if (cnt_q != 2'd0) begin
          dig_d = dig_q >> BCD_W;
          cnt_d = cnt_q - 2'd1;
        end else begin
          state_d = ST_CONV;
        end
      end

      ST_CONV: begin
        acc_d = (acc_q << 3) + (acc_q << 1) + BIN_W'(cur_digit);
        if (idx_q == 3'(DIGITS - 1)) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end

      ST_DONE: begin
        done_tick = 1'b1;
        state_d   = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bcd6    = dig_q[6*BCD_W +: BCD_W];
  assign bcd5    = dig_q[5*BCD_W +: BCD_W];
  assign bcd4    = dig_q[4*BCD_W +: BCD_W];
  assign bcd3    = dig_q[3*BCD_W +: BCD_W];
  assign bcd2    = dig_q[2*BCD_W +: BCD_W];
  assign bcd1    = dig_q[1*BCD_W +: BCD_W];
  assign bcd0    = dig_q[0*BCD_W +: BCD_W];
  assign bin_out = acc_q;

endmodule

// File: tb/tb_bcd_expand.sv
// Directed-vector bench for bcd_expand.
module tb_bcd_expand;

  localparam int BIN_W = 24;

  logic             clk;
  logic             reset;
  logic             start;
  logic [3:0]       bcd_in3, bcd_in2, bcd_in1, bcd_in0;
  logic [1:0]       decimal_counter;
  logic [3:0]       bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0;
  logic [BIN_W-1:0] bin_out;
  logic             ready;
  logic             done_tick;

  int n_checks = 0;
  int n_fail   = 0;

  bcd_expand #(.BIN_W(BIN_W)) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .bcd_in3         (bcd_in3),
    .bcd_in2         (bcd_in2),
    .bcd_in1         (bcd_in1),
    .bcd_in0         (bcd_in0),
    .decimal_counter (decimal_counter),
    .bcd6            (bcd6),
    .bcd5            (bcd5),
    .bcd4            (bcd4),
    .bcd3            (bcd3),
    .bcd2            (bcd2),
    .bcd1            (bcd1),
    .bcd0            (bcd0),
    .bin_out         (bin_out),
    .ready           (ready),
    .done_tick       (done_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] bcd_packed();
    return {4'h0, bcd6, bcd5, bcd4, bcd3, bcd2, bcd1, bcd0};
  endfunction

  // One operation from idle. Cycle n is the period following the n-th edge
  // after the start edge; done_tick must appear in cycle lat and nowhere else.
  task automatic run_op(input string tag,
                        input logic [3:0] m3, input logic [3:0] m2,
                        input logic [3:0] m1, input logic [3:0] m0,
                        input logic [1:0] dc,
                        input logic [31:0] exp_bcd, input logic [31:0] exp_bin,
                        input int lat, input bit pulse_busy);
    int done_cycle = 0;
    int done_count = 0;
    int ready_busy = 0;
    bcd_in3 = m3; bcd_in2 = m2; bcd_in1 = m1; bcd_in0 = m0;
    decimal_counter = dc;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      if (pulse_busy && n == 3) start = 1'b1;
      if (pulse_busy && n == 5) start = 1'b0;
      if (done_tick) begin
        done_count++;
        if (done_cycle == 0) done_cycle = n;
      end
      if (n <= lat && ready) ready_busy++;
      if (n == lat) begin
        check({tag, "_bcd"}, bcd_packed(), exp_bcd);
        check({tag, "_bin"}, 32'(bin_out), exp_bin);
      end
    end
    check({tag, "_latency"}, 32'(done_cycle), 32'(lat));
    check({tag, "_done_count"}, 32'(done_count), 32'd1);
    check({tag, "_ready_busy"}, 32'(ready_busy), 32'd0);
    check({tag, "_hold_bin"}, 32'(bin_out), exp_bin);
    check({tag, "_ready_idle"}, 32'(ready), 32'd1);
  endtask

  initial begin
    int first_done, second_done, ready_cycles, ready_at_12, dt_in_reset;
    reset = 1'b0;
    start = 1'b0;
    bcd_in3 = '0; bcd_in2 = '0; bcd_in1 = '0; bcd_in0 = '0;
    decimal_counter = '0;
    #1;
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done_tick), 32'd0);
    check("rst_bin", 32'(bin_out), 32'd0);
    check("rst_bcd", bcd_packed(), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    run_op("t1", 4'd1, 4'd2, 4'd3, 4'd4, 2'd3, 32'h0001234, 32'd1234,    12, 1'b0);
    run_op("t2", 4'd9, 4'd8, 4'd7, 4'd6, 2'd0, 32'h9876000, 32'h96B220,   9, 1'b0);
    run_op("t3", 4'd5, 4'd0, 4'd0, 4'd1, 2'd1, 32'h0500100, 32'd500100,  10, 1'b1);
    run_op("t4", 4'd0, 4'd0, 4'd0, 4'd9, 2'd3, 32'h0000009, 32'd9,       12, 1'b0);
    // Non-BCD nibble: processed arithmetically, 10 * 10^6.
    run_op("t5", 4'hA, 4'd0, 4'd0, 4'd0, 2'd0, 32'hA000000, 32'd10000000, 9, 1'b0);

    // Start held high: 1,2,3,4 with count 2 -> latency 11, restart in cycle 12.
    first_done = 0; second_done = 0; ready_cycles = 0; ready_at_12 = 0;
    bcd_in3 = 4'd1; bcd_in2 = 4'd2; bcd_in1 = 4'd3; bcd_in0 = 4'd4;
    decimal_counter = 2'd2;
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int n = 1; n <= 30; n++) begin
      if (n > 1) begin
        @(posedge clk);
        #1;
      end
      if (done_tick) begin
        if (first_done == 0) first_done = n;
        else if (second_done == 0) second_done = n;
      end
      if (ready) ready_cycles++;
      if (n == 12) ready_at_12 = int'(ready);
      if (n == 23) begin
        start = 1'b0;
        check("held_bcd", bcd_packed(), 32'h0012340);
        check("held_bin", 32'(bin_out), 32'd12340);
      end
    end
    check("held_first_done", 32'(first_done), 32'd11);
    check("held_second_done", 32'(second_done), 32'd23);
    check("held_ready_at_idle", 32'(ready_at_12), 32'd1);
    // Cycle 12 idle, then idle again from cycle 24 through 30.
    check("held_ready_cycles", 32'(ready_cycles), 32'd8);

    // Reset mid-conversion: 9,8,7,6 count 0, three digits accumulated in cycle 5.
    bcd_in3 = 4'd9; bcd_in2 = 4'd8; bcd_in1 = 4'd7; bcd_in0 = 4'd6;
    decimal_counter = 2'd0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_acc", 32'(bin_out), 32'd987);
    check("mid_ready", 32'(ready), 32'd0);
    #1;
    reset = 1'b0;
    #1;
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_bin", 32'(bin_out), 32'd0);
    check("abort_bcd", bcd_packed(), 32'd0);
    dt_in_reset = 0;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (done_tick) dt_in_reset++;
    end
    @(negedge clk);
    reset = 1'b1;
    for (int n = 0; n < 8; n++) begin
      @(posedge clk);
      #1;
      if (done_tick) dt_in_reset++;
    end
    check("abort_no_done", 32'(dt_in_reset), 32'd0);

    run_op("t6", 4'd0, 4'd0, 4'd0, 4'd0, 2'd0, 32'h0000000, 32'd0, 9, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
